axi_lite_cfg_sequencer: RTL



---
 rtl/axi_lite_cfg_sequencer.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_cfg_sequencer.sv
// AXI-lite master that walks a configuration table, writing each entry and
// optionally reading it back for comparison; stops on the first failure.
module axi_lite_cfg_sequencer #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_ENTRIES    = 8,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int IDX_W         = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              err_code,
  output logic [IDX_W-1:0]        err_index,
  output logic [IDX_W-1:0]        tbl_idx,
  input  logic [ADDR_WIDTH-1:0]   tbl_addr,
  input  logic [DATA_WIDTH-1:0]   tbl_data,
  input  logic                    tbl_verify,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    NEXT    = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_BRESP   = 2'b01;
  localparam logic [1:0] ERR_VERIFY  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WD_W-1:0]  wdog;
  logic             in_wait;
  logic             phase_exit;
  logic             wd_expire;
  logic             last_entry;
  logic             rd_bad;

  assign wstrb      = '1;
  assign dbg_state  = state;
  assign wd_expire  = (wdog == WD_MAX);
  assign last_entry = (idx == LAST_IDX);
  assign rd_bad     = (rresp != 2'b00) || (rdata != tbl_data);

  // Handshake rule on every channel: a transfer happens on the rising edge
  // where valid && ready; the source holds valid and payload stable until then
  // and drops valid on the following cycle unless a new transfer is queued.
  always_comb begin
    in_wait    = 1'b0;
    phase_exit = 1'b0;
    case (state)
      WR_REQ: begin
        in_wait    = 1'b1;
        phase_exit = (!awvalid || awready) && (!wvalid || wready);
      end
      WR_RESP: begin
        in_wait    = 1'b1;
        phase_exit = bvalid;
      end
      RD_REQ: begin
        in_wait    = 1'b1;
        phase_exit = arready;
      end
      RD_DATA: begin
        in_wait    = 1'b1;
        phase_exit = rvalid;
      end
      default: begin
        in_wait    = 1'b0;
        phase_exit = 1'b0;
      end
    endcase
  end

  // In NEXT the table is already looking at the following entry so the
  // address/data can be registered on the same edge that re-enters WR_REQ.
  always_comb begin
    tbl_idx = idx;
    if (state == NEXT && !last_entry) tbl_idx = idx + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      wdog      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_code  <= ERR_OK;
      err_index <= '0;
      awaddr    <= '0;
      wdata     <= '0;
      araddr    <= '0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
    end else begin
      wdog <= '0;
      if (in_wait && !phase_exit && wd_expire) begin
        state     <= DONE;
        done      <= 1'b1;
        err_code  <= ERR_TIMEOUT;
        err_index <= idx;
        awvalid   <= 1'b0;
        wvalid    <= 1'b0;
        bready    <= 1'b0;
        arvalid   <= 1'b0;
        rready    <= 1'b0;
      end else begin
        if (in_wait && !phase_exit) wdog <= wdog + 1'b1;
        case (state)
          IDLE: begin
            if (start) begin
              idx       <= '0;
              err_code  <= ERR_OK;
              err_index <= '0;
              busy      <= 1'b1;
              awaddr    <= tbl_addr;
              wdata     <= tbl_data;
              awvalid   <= 1'b1;
              wvalid    <= 1'b1;
              state     <= WR_REQ;
            end
          end
          WR_REQ: begin
            if (awvalid && awready) awvalid <= 1'b0;
            if (wvalid && wready) wvalid <= 1'b0;
            if (phase_exit) begin
              bready <= 1'b1;
              state  <= WR_RESP;
            end
          end
          WR_RESP: begin
            if (bvalid) begin
              bready <= 1'b0;
              if (bresp != 2'b00) begin
                err_code  <= ERR_BRESP;
                err_index <= idx;
                done      <= 1'b1;
                state     <= DONE;
              end else if (tbl_verify) begin
                araddr  <= tbl_addr;
                arvalid <= 1'b1;
                state   <= RD_REQ;
              end else begin
                state <= NEXT;
              end
            end
          end
          RD_REQ: begin
            if (arready) begin
              arvalid <= 1'b0;
              rready  <= 1'b1;
              state   <= RD_DATA;
            end
          end
          RD_DATA: begin
            if (rvalid) begin
              rready <= 1'b0;
              if (rd_bad) begin
                err_code  <= ERR_VERIFY;
                err_index <= idx;
                done      <= 1'b1;
                state     <= DONE;
              end else begin
                state <= NEXT;
              end
            end
          end
          NEXT: begin
            if (last_entry) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx     <= idx + 1'b1;
              awaddr  <= tbl_addr;
              wdata   <= tbl_data;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WR_REQ;
            end
          end
          DONE: begin
            done  <= 1'b0;
            busy  <= 1'b0;
            idx   <= '0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
